// File: rtl/rv32_pkg.sv
// Shared writeback types and widths for the register-bank write path.
// Holds the default data/address widths and the port identifiers used by the arbiter.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_LSU = 1'b1
    } port_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       din;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flop updated on grant.
// Zero latency; grants nothing while enable is low and then leaves priority untouched.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);
    import rv32_pkg::*;

    port_e prio;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio == PORT_LSU) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Whoever was just served drops to the back of the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= PORT_ALU;
        end else if (|gnt) begin
            prio <= gnt[0] ? PORT_LSU : PORT_ALU;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register bank write port between ALU and LSU writebacks, dropping x0 writes.
// One cycle accept-to-write latency; stall blocks both ports, losers retry with their request held.
module reg_wb_arbiter #(
    parameter int XLEN       = rv32_pkg::XLEN,
    parameter int REG_ADDR_W = rv32_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_waddr,
    input  logic [XLEN-1:0]       alu_din,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_waddr,
    input  logic [XLEN-1:0]       lsu_din,
    output logic                  w_enable,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       din,
    output logic                  last_grant,
    output logic [CNT_W-1:0]      conflict_cnt
);
    import rv32_pkg::*;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       din;
    } req_t;

    req_t       alu_req;
    req_t       lsu_req;
    logic       run;
    logic       alu_x0;
    logic       lsu_x0;
    logic [1:0] real_req;
    logic [1:0] gnt;
    logic       conflict;

    assign alu_req = '{valid: alu_valid, waddr: alu_waddr, din: alu_din};
    assign lsu_req = '{valid: lsu_valid, waddr: lsu_waddr, din: lsu_din};

    assign run    = !stall;
    assign alu_x0 = (alu_req.waddr == '0);
    assign lsu_x0 = (lsu_req.waddr == '0);

    // x0 requests never reach the arbiter, so they cannot win, lose or move priority.
    assign real_req = {lsu_req.valid && !lsu_x0, alu_req.valid && !alu_x0};
    assign conflict = run && (&real_req);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (real_req),
        .enable (run),
        .gnt    (gnt)
    );

    assign alu_ready = run && alu_req.valid && (alu_x0 || gnt[0]);
    assign lsu_ready = run && lsu_req.valid && (lsu_x0 || gnt[1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            w_enable     <= 1'b0;
            waddr        <= '0;
            din          <= '0;
            last_grant   <= PORT_ALU;
            conflict_cnt <= '0;
        end else begin
            w_enable <= |gnt;
            if (gnt[1]) begin
                waddr      <= lsu_req.waddr;
                din        <= lsu_req.din;
                last_grant <= PORT_LSU;
            end else if (gnt[0]) begin
                waddr      <= alu_req.waddr;
                din        <= alu_req.din;
                last_grant <= PORT_ALU;
            end
            if (conflict && !(&conflict_cnt)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: vector table plus hand sequences, with a reg_bank model on the write port.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_waddr, lsu_waddr;
    logic [31:0] alu_din, lsu_din;
    logic        alu_ready, lsu_ready;
    logic        w_enable;
    logic [4:0]  waddr;
    logic [31:0] din;
    logic        last_grant;
    logic [15:0] conflict_cnt;

    logic        s_alu_ready, s_lsu_ready, s_w_enable, s_last_grant;
    logic [4:0]  s_waddr;
    logic [31:0] s_din;
    logic [1:0]  s_cnt;

    logic        rf_clr;
    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_bad = 0;

    reg_wb_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_din(alu_din),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_din(lsu_din),
        .w_enable(w_enable), .waddr(waddr), .din(din),
        .last_grant(last_grant), .conflict_cnt(conflict_cnt)
    );

    reg_wb_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall),
        .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_waddr(alu_waddr), .alu_din(alu_din),
        .lsu_valid(lsu_valid), .lsu_ready(s_lsu_ready), .lsu_waddr(lsu_waddr), .lsu_din(lsu_din),
        .w_enable(s_w_enable), .waddr(s_waddr), .din(s_din),
        .last_grant(s_last_grant), .conflict_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reg_bank stand-in: writes any address, so a leaked x0 write is visible.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (w_enable) begin
            rf[waddr] <= din;
        end
    end

    typedef struct {
        logic        stall;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        ar;
        logic        lr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        lg;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        stall     = st;
        alu_valid = av;
        alu_waddr = aa;
        alu_din   = ad;
        lsu_valid = lv;
        lsu_waddr = la;
        lsu_din   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rf_clr = 1'b1;
        reset  = 1'b1;
        drive(0, 1, 5'd2, 32'd22, 1, 5'd3, 32'd33);
        tick();
        tick();
        rf_clr = 1'b0;
        check("reset_w_enable", w_enable, 0);
        check("reset_waddr", waddr, 0);
        check("reset_din", din, 0);
        check("reset_last_grant", last_grant, 0);
        check("reset_cnt", conflict_cnt, 0);
        reset = 1'b0;

        //              st av aa    ad      lv la    ld      ar lr we wa     wd      lg cnt
        vecs.push_back('{0, 1, 5'd1,  32'd10,  0, 5'd0,  32'd0,   1, 0, 1, 5'd1,  32'd10,  0, 0});
        vecs.push_back('{0, 0, 5'd0,  32'd0,   0, 5'd0,  32'd0,   0, 0, 0, 5'd1,  32'd10,  0, 0});
        vecs.push_back('{0, 0, 5'd0,  32'd0,   1, 5'd7,  32'd70,  0, 1, 1, 5'd7,  32'd70,  1, 0});
        vecs.push_back('{0, 1, 5'd2,  32'd2,   1, 5'd3,  32'd3,   1, 0, 1, 5'd2,  32'd2,   0, 1});
        vecs.push_back('{0, 0, 5'd0,  32'd0,   1, 5'd3,  32'd3,   0, 1, 1, 5'd3,  32'd3,   1, 1});
        vecs.push_back('{0, 1, 5'd8,  32'd80,  1, 5'd9,  32'd90,  1, 0, 1, 5'd8,  32'd80,  0, 2});
        vecs.push_back('{0, 0, 5'd0,  32'd0,   1, 5'd9,  32'd90,  0, 1, 1, 5'd9,  32'd90,  1, 2});
        vecs.push_back('{0, 1, 5'd0,  32'd10,  1, 5'd4,  32'd7,   1, 1, 1, 5'd4,  32'd7,   1, 2});
        vecs.push_back('{0, 1, 5'd0,  32'd10,  0, 5'd0,  32'd0,   1, 0, 0, 5'd4,  32'd7,   1, 2});
        vecs.push_back('{1, 1, 5'd10, 32'd100, 1, 5'd11, 32'd110, 0, 0, 0, 5'd4,  32'd7,   1, 2});
        vecs.push_back('{0, 1, 5'd10, 32'd100, 1, 5'd11, 32'd110, 1, 0, 1, 5'd10, 32'd100, 0, 3});
        vecs.push_back('{0, 0, 5'd0,  32'd0,   1, 5'd11, 32'd110, 0, 1, 1, 5'd11, 32'd110, 1, 3});
        vecs.push_back('{0, 1, 5'd0,  32'd5,   1, 5'd0,  32'd6,   1, 1, 0, 5'd11, 32'd110, 1, 3});
        vecs.push_back('{1, 1, 5'd0,  32'd5,   0, 5'd0,  32'd0,   0, 0, 0, 5'd11, 32'd110, 1, 3});
        vecs.push_back('{0, 1, 5'd12, 32'd120, 0, 5'd0,  32'd0,   1, 0, 1, 5'd12, 32'd120, 0, 3});
        vecs.push_back('{0, 1, 5'd13, 32'd130, 1, 5'd14, 32'd140, 0, 1, 1, 5'd14, 32'd140, 1, 4});
        vecs.push_back('{0, 1, 5'd13, 32'd130, 0, 5'd0,  32'd0,   1, 0, 1, 5'd13, 32'd130, 0, 4});
        vecs.push_back('{0, 0, 5'd0,  32'd0,   1, 5'd15, 32'd150, 0, 1, 1, 5'd15, 32'd150, 1, 4});

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
            #1;
            check($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].ar);
            check($sformatf("v%0d_lsu_ready", i), lsu_ready, vecs[i].lr);
            tick();
            check($sformatf("v%0d_w_enable", i), w_enable, vecs[i].we);
            check($sformatf("v%0d_waddr", i), waddr, vecs[i].wa);
            check($sformatf("v%0d_din", i), din, vecs[i].wd);
            check($sformatf("v%0d_last_grant", i), last_grant, vecs[i].lg);
            check($sformatf("v%0d_cnt", i), conflict_cnt, vecs[i].cnt);
            check($sformatf("v%0d_cnt_sat", i), s_cnt, (vecs[i].cnt > 3) ? 3 : vecs[i].cnt);
        end

        // Same destination from both ports: serialized, loser's data lands last.
        drive(0, 1, 5'd6, 32'd1, 1, 5'd6, 32'd2);
        #1;
        check("same_alu_ready", alu_ready, 1);
        check("same_lsu_ready", lsu_ready, 0);
        tick();
        check("same_first_din", din, 1);
        drive(0, 0, 5'd0, 32'd0, 1, 5'd6, 32'd2);
        #1;
        check("same_lsu_ready2", lsu_ready, 1);
        tick();
        check("same_second_we", w_enable, 1);
        check("same_second_din", din, 2);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick();
        check("same_rf_x6", rf[6], 2);
        check("cnt_after_5", conflict_cnt, 5);
        check("cnt_sat_after_5", s_cnt, 3);
        check("rf_x1", rf[1], 10);
        check("rf_x4", rf[4], 7);
        check("rf_x0_untouched", rf[0], 0);

        // Stall, then reset arriving with an accepted request drops the write.
        drive(1, 1, 5'd2, 32'd2, 1, 5'd3, 32'd3);
        #1;
        check("stall_alu_ready", alu_ready, 0);
        check("stall_lsu_ready", lsu_ready, 0);
        tick();
        check("stall_w_enable", w_enable, 0);
        drive(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'd9);
        reset = 1'b1;
        tick();
        check("rst_mid_w_enable", w_enable, 0);
        check("rst_mid_cnt", conflict_cnt, 0);
        check("rst_mid_last_grant", last_grant, 0);
        check("rst_mid_waddr", waddr, 0);
        reset = 1'b0;
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick();
        check("rst_after_w_enable", w_enable, 0);
        check("rst_rf_x5", rf[5], 0);
        drive(0, 1, 5'd2, 32'd2, 1, 5'd3, 32'd3);
        #1;
        check("rst_prio_alu_ready", alu_ready, 1);
        check("rst_prio_lsu_ready", lsu_ready, 0);
        tick();
        check("rst_prio_waddr", waddr, 2);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
